// File: rtl/fu_credit_queue_if.sv
// fu_credit_queue_if: operand, credit and completion bundle between a switch, the FU and the queue stage.
`ifndef PATH_BITS
`define PATH_BITS 32
`endif
interface fu_credit_queue_if #(
  parameter int BITS  = `PATH_BITS,
  parameter int DEPTH = 2
);
  logic                       valid_in;
  logic [BITS-1:0]            data_in;
  logic                       credit_in;
  logic                       done;
  logic                       valid_out;
  logic [BITS-1:0]            data_out;
  logic                       credit_out;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  logic                       err;
  modport master (
    output valid_in, data_in, credit_in, done,
    input  valid_out, data_out, credit_out, occupancy, err
  );
  modport slave (
    input  valid_in, data_in, credit_in, done,
    output valid_out, data_out, credit_out, occupancy, err
  );
endinterface

// File: rtl/fu_credit_queue.sv
// fu_credit_queue: credit-gated operand queue feeding one FU, completion by external done or fixed latency.
`ifndef PATH_BITS
`define PATH_BITS 32
`endif
module fu_credit_queue #(
  parameter int ID          = 0,
  parameter int BITS        = `PATH_BITS,
  parameter int DEPTH       = 2,
  parameter int CREDITS     = 1,
  parameter int MAX_CREDITS = 4,
  parameter int LATENCY     = 0
) (
  input logic              clk,
  input logic              rst,
  fu_credit_queue_if.slave io_bus
);
  localparam int CW = $clog2(MAX_CREDITS + 1);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(LATENCY + 2);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t          r_state, w_state;
  logic [BITS-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_head, r_tail, w_next;
  logic [OW-1:0]   r_occ;
  logic [CW-1:0]   r_cred;
  logic [LW-1:0]   r_lat;
  logic [BITS-1:0] r_data;
  logic            r_credit_out, r_err;
  logic            w_busy, w_cpl, w_pend, w_bypass, w_issue, w_push, w_drop, w_ovf, w_bad_done;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // The in-service operand stays at the queue head until completion, so the next candidate sits behind it.
  always_comb begin
    w_busy     = r_state == BUSY;
    w_cpl      = w_busy && (LATENCY == 0 ? io_bus.done : r_lat == LW'(1));
    w_pend     = w_busy ? r_occ > OW'(1) : r_occ != '0;
    w_bypass   = !w_pend && io_bus.valid_in;
    w_issue    = (!w_busy || w_cpl) && (w_pend || io_bus.valid_in) && (r_cred != '0 || io_bus.credit_in);
    w_push     = io_bus.valid_in && (r_occ != OW'(DEPTH) || w_cpl);
    w_drop     = io_bus.valid_in && !w_push;
    w_ovf      = io_bus.credit_in && !w_issue && r_cred == CW'(MAX_CREDITS);
    w_bad_done = LATENCY == 0 && io_bus.done && !w_busy;
    w_next     = w_busy ? inc(r_head) : r_head;
    w_state    = w_issue ? BUSY : w_cpl ? IDLE : r_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_head       <= '0;
      r_tail       <= '0;
      r_occ        <= '0;
      r_cred       <= CW'(CREDITS);
      r_lat        <= '0;
      r_data       <= '0;
      r_credit_out <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_credit_out <= w_cpl;
      r_err        <= r_err | w_drop | w_ovf | w_bad_done;
      r_occ        <= r_occ + OW'(w_push) - OW'(w_cpl);
      r_cred       <= r_cred + CW'(io_bus.credit_in && !w_ovf) - CW'(w_issue);
      r_lat        <= w_issue ? LW'(LATENCY) : (w_busy && r_lat != '0) ? r_lat - 1'b1 : r_lat;
      if (w_push) r_tail <= inc(r_tail);
      if (w_cpl) r_head <= inc(r_head);
      if (w_issue) r_data <= w_bypass ? io_bus.data_in : r_mem[w_next];
    end
  end

  always_ff @(posedge clk)
    if (w_push) r_mem[r_tail] <= io_bus.data_in;

  assign io_bus.valid_out  = r_state == BUSY;
  assign io_bus.data_out   = r_data;
  assign io_bus.credit_out = r_credit_out;
  assign io_bus.occupancy  = r_occ;
  assign io_bus.err        = r_err;
endmodule

// File: tb/tb_fu_credit_queue.sv
// tb_fu_credit_queue: scoreboard bench over external-done, zero-credit and fixed-latency instances.
module tb_fu_credit_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] sb[$];
  logic [31:0] sbc[$];
  logic mon_c = 1'b0;
  int vcnt = 0;
  int n_cred_c = 0;

  always #5 clk = ~clk;

  fu_credit_queue_if #(.BITS(32), .DEPTH(2)) a ();
  fu_credit_queue_if #(.BITS(32), .DEPTH(2)) b ();
  fu_credit_queue_if #(.BITS(32), .DEPTH(4)) c ();

  fu_credit_queue #(.ID(0), .BITS(32), .DEPTH(2), .CREDITS(1), .MAX_CREDITS(4), .LATENCY(0))
    u_a (.clk(clk), .rst(rst), .io_bus(a.slave));
  fu_credit_queue #(.ID(1), .BITS(32), .DEPTH(2), .CREDITS(0), .MAX_CREDITS(4), .LATENCY(0))
    u_b (.clk(clk), .rst(rst), .io_bus(b.slave));
  fu_credit_queue #(.ID(2), .BITS(32), .DEPTH(4), .CREDITS(4), .MAX_CREDITS(4), .LATENCY(3))
    u_c (.clk(clk), .rst(rst), .io_bus(c.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Fixed-latency instance: each queued operand must be presented for exactly three valid cycles in order.
  always @(negedge clk) begin
    if (mon_c) begin
      if (c.credit_out) n_cred_c++;
      if (c.valid_out) begin
        if (sbc.size() == 0) check("c_extra", c.valid_out, 1'b0);
        else begin
          check("c_data", c.data_out, sbc[0]);
          vcnt++;
          if (vcnt == 3) begin
            void'(sbc.pop_front());
            vcnt = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] vals [3];
    int run;
    vals = '{32'h1, 32'h2, 32'h3};
    {a.valid_in, a.credit_in, a.done} = '0;
    {b.valid_in, b.credit_in, b.done} = '0;
    {c.valid_in, c.credit_in, c.done} = '0;
    a.data_in = '0;
    b.data_in = '0;
    c.data_in = '0;

    do_reset;
    check("rst_valid", a.valid_out, 1'b0);
    check("rst_data", a.data_out, 32'h0);
    check("rst_credit", a.credit_out, 1'b0);
    check("rst_err", a.err, 1'b0);
    check("rst_occ", a.occupancy, 0);
    a.valid_in = 1'b1;
    a.data_in = 32'h11;
    sb.push_back(32'h11);
    tick;
    a.valid_in = 1'b0;
    check("a_issue_valid", a.valid_out, 1'b1);
    check("a_issue_data", a.data_out, sb[0]);
    check("a_issue_occ", a.occupancy, 1);
    tick;
    tick;
    check("a_hold_valid", a.valid_out, 1'b1);
    a.done = 1'b1;
    check("a_done_data", a.data_out, sb.pop_front());
    tick;
    a.done = 1'b0;
    check("a_cpl_valid", a.valid_out, 1'b0);
    check("a_cpl_credit", a.credit_out, 1'b1);
    check("a_cpl_occ", a.occupancy, 0);
    a.done = 1'b1;
    tick;
    a.done = 1'b0;
    check("a_idle_done_err", a.err, 1'b1);
    check("a_idle_done_credit", a.credit_out, 1'b0);
    check("a_idle_done_valid", a.valid_out, 1'b0);
    check("a_idle_done_data", a.data_out, 32'h11);
    check("a_idle_done_occ", a.occupancy, 0);

    do_reset;
    b.valid_in = 1'b1;
    b.data_in = 32'hA;
    sb.push_back(32'hA);
    tick;
    b.valid_in = 1'b0;
    check("b_nocred_valid", b.valid_out, 1'b0);
    check("b_nocred_occ", b.occupancy, 1);
    tick;
    check("b_wait_valid", b.valid_out, 1'b0);
    b.credit_in = 1'b1;
    tick;
    b.credit_in = 1'b0;
    check("b_credit_valid", b.valid_out, 1'b1);
    check("b_credit_data", b.data_out, sb[0]);
    b.valid_in = 1'b1;
    b.data_in = 32'hB;
    sb.push_back(32'hB);
    tick;
    b.data_in = 32'hC;
    tick;
    b.valid_in = 1'b0;
    check("b_full_occ", b.occupancy, 2);
    check("b_full_err", b.err, 1'b1);
    b.done = 1'b1;
    check("b_done_data", b.data_out, sb.pop_front());
    tick;
    b.done = 1'b0;
    check("b_stall_valid", b.valid_out, 1'b0);
    check("b_stall_occ", b.occupancy, 1);
    check("b_stall_credit", b.credit_out, 1'b1);
    b.credit_in = 1'b1;
    tick;
    b.credit_in = 1'b0;
    check("b_next_valid", b.valid_out, 1'b1);
    check("b_next_data", b.data_out, sb[0]);
    sb.delete();

    do_reset;
    a.valid_in = 1'b1;
    a.data_in = 32'h21;
    tick;
    a.data_in = 32'h22;
    tick;
    a.data_in = 32'h23;
    tick;
    a.valid_in = 1'b0;
    check("r_pre_occ", a.occupancy, 2);
    check("r_pre_valid", a.valid_out, 1'b1);
    check("r_pre_err", a.err, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("r_async_valid", a.valid_out, 1'b0);
    check("r_async_occ", a.occupancy, 0);
    check("r_async_err", a.err, 1'b0);
    rst = 1'b0;
    a.valid_in = 1'b1;
    a.data_in = 32'h24;
    tick;
    a.valid_in = 1'b0;
    check("r_post_valid", a.valid_out, 1'b1);
    check("r_post_data", a.data_out, 32'h24);

    do_reset;
    b.credit_in = 1'b1;
    repeat (4) tick;
    check("b_cred_max_err", b.err, 1'b0);
    tick;
    b.credit_in = 1'b0;
    check("b_cred_ovf_err", b.err, 1'b1);

    do_reset;
    mon_c = 1'b1;
    run = 0;
    for (int i = 0; i < 3; i++) begin
      c.valid_in = 1'b1;
      c.data_in = vals[i];
      sbc.push_back(vals[i]);
      tick;
      run += int'(c.valid_out);
    end
    c.valid_in = 1'b0;
    repeat (7) begin
      tick;
      run += int'(c.valid_out);
    end
    check("c_run", run, 9);
    check("c_end_valid", c.valid_out, 1'b0);
    check("c_end_credit", c.credit_out, 1'b1);
    c.valid_in = 1'b1;
    c.data_in = 32'h4;
    sbc.push_back(32'h4);
    tick;
    c.data_in = 32'h5;
    sbc.push_back(32'h5);
    tick;
    c.valid_in = 1'b0;
    check("c_two_occ", c.occupancy, 2);
    tick;
    tick;
    check("c_lastcred_valid", c.valid_out, 1'b0);
    check("c_lastcred_occ", c.occupancy, 1);
    check("c_lastcred_credit", c.credit_out, 1'b1);
    c.credit_in = 1'b1;
    tick;
    c.credit_in = 1'b0;
    check("c_refill_valid", c.valid_out, 1'b1);
    repeat (3) tick;
    check("c_drain_valid", c.valid_out, 1'b0);
    check("c_drain_occ", c.occupancy, 0);
    tick;
    mon_c = 1'b0;
    check("c_pulses", n_cred_c, 5);
    check("c_sb_empty", sbc.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
